// File: rtl/pp_generator.sv
// Two-stage partial-product generator for a 16x16 multiplier. It produces
// operand magnitudes plus a negate flag, then 16 shifted rows for a 4:2 compressor tree.
module pp_generator (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  a,
    input  logic [15:0]  b,
    input  logic         signed_mode,
    input  logic [3:0]   tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] x,
    output logic         neg,
    output logic [3:0]   tag_out
);

    logic         s1_valid;
    logic [15:0]  s1_a_mag;
    logic [15:0]  s1_b_mag;
    logic         s1_neg;
    logic [3:0]   s1_tag;
    logic         s2_valid;

    logic         s1_adv;
    logic         s2_adv;
    logic [15:0]  a_mag;
    logic [15:0]  b_mag;
    logic         in_neg;
    logic [511:0] pp;

    // A stage may load when it is empty or when its contents move on this edge.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Two's complement negation maps 0x8000 to itself, which is the correct unsigned magnitude.
    assign a_mag  = (signed_mode && a[15]) ? (~a + 16'd1) : a;
    assign b_mag  = (signed_mode && b[15]) ? (~b + 16'd1) : b;
    assign in_neg = signed_mode && (a[15] ^ b[15]) && (a != 16'd0) && (b != 16'd0);

    always_comb begin
        // NOTE: a default assignment before any conditional write keeps this
        // block purely combinational; a missing default infers a latch.
        pp = '0;
        for (int i = 0; i < 16; i++) begin
            if (s1_b_mag[i]) begin
                pp[i*32 +: 32] = {16'b0, s1_a_mag} << i;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            x        <= '0;
            neg      <= 1'b0;
            tag_out  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    x       <= pp;
                    neg     <= s1_neg;
                    tag_out <= s1_tag;
                end
            end
        end
    end

    // NOTE: S1 datapath registers carry no reset; they are only ever observed
    // behind s1_valid, so resetting them would add fanout for no behaviour.
    always_ff @(posedge clk) begin
        if (!rst && in_valid && s1_adv) begin
            s1_a_mag <= a_mag;
            s1_b_mag <= b_mag;
            s1_neg   <= in_neg;
            s1_tag   <= tag;
        end
    end

endmodule

// File: tb/tb_pp_generator.sv
// Self-checking bench for pp_generator: directed table, backpressure and reset
// sequences, plus a random stream checked by a queue-based arithmetic model.
module tb_pp_generator;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  a;
    logic [15:0]  b;
    logic         signed_mode;
    logic [3:0]   tag;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] x;
    logic         neg;
    logic [3:0]   tag_out;

    int vectors     = 0;
    int miscompares = 0;
    int in_cnt      = 0;
    int out_cnt     = 0;

    typedef struct {
        logic [15:0] a_mag;
        logic [15:0] b_mag;
        logic [31:0] prod;
        logic        neg;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [3:0]  tag;
        logic [31:0] prod;
        logic        neg;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    logic         stalled_prev = 1'b0;
    logic [511:0] prev_x;
    logic         prev_neg;
    logic [3:0]   prev_tag;

    pp_generator dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .tag         (tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .x           (x),
        .neg         (neg),
        .tag_out     (tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] magnitude(input logic [15:0] v, input logic sm);
        int s;
        if (!sm) return v;
        s = int'($signed(v));
        if (s < 0) s = -s;
        return 16'(s);
    endfunction

    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic sm, input logic [3:0] t);
        exp_t e;
        e.a_mag = magnitude(av, sm);
        e.b_mag = magnitude(bv, sm);
        e.prod  = 32'(longint'(e.a_mag) * longint'(e.b_mag));
        e.neg   = sm && (($signed(av) < 0) != ($signed(bv) < 0)) && (av != 0) && (bv != 0);
        e.tag   = t;
        return e;
    endfunction

    function automatic longint row_sum(input logic [511:0] v);
        longint s = 0;
        for (int i = 0; i < 16; i++) s += longint'(v[i*32 +: 32]);
        return s;
    endfunction

    // Output monitor: every transfer is compared against the acceptance-ordered model queue.
    always @(negedge clk) begin : monitor
        exp_t   e;
        longint row_exp;
        if (rst) begin
            exp_q.delete();
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_x",     64'(x == prev_x), 64'd1);
                check("stall_neg",   64'(neg), 64'(prev_neg));
                check("stall_tag",   64'(tag_out), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    out_cnt++;
                    for (int i = 0; i < 16; i++) begin
                        row_exp = e.b_mag[i] ? longint'(e.a_mag) * (longint'(1) << i) : 0;
                        check($sformatf("row%0d", i), 64'(x[i*32 +: 32]), 64'(row_exp));
                    end
                    check("row_sum", 64'(row_sum(x)), 64'(e.prod));
                    check("neg",     64'(neg), 64'(e.neg));
                    check("tag",     64'(tag_out), 64'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, signed_mode, tag));
                in_cnt++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_x       = x;
            prev_neg     = neg;
            prev_tag     = tag_out;
        end
    end

    // Single pair through an idle pipeline with out_ready high: checks the two-edge latency.
    task automatic send_one(input vec_t v);
        a = v.a; b = v.b; signed_mode = v.sm; tag = v.tag; in_valid = 1'b1;
        #1;
        check("vec_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("vec_lat_n1", 64'(out_valid), 64'd0);
        tick();
        check("vec_lat_n2", 64'(out_valid), 64'd1);
        check("vec_sum",    64'(row_sum(x)), 64'(v.prod));
        check("vec_neg",    64'(neg), 64'(v.neg));
        check("vec_tag",    64'(tag_out), 64'(v.tag));
        tick();
        check("vec_done",   64'(out_valid), 64'd0);
    endtask

    task automatic drain(input string name);
        int c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && c < 50) begin
            tick();
            c++;
        end
        check(name, 64'(exp_q.size() != 0 || out_valid), 64'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int acc;
        int cyc;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 4'd1, 32'hFFFE0001, 1'b0};
        vecs[1] = '{16'h8000, 16'h0003, 1'b1, 4'd2, 32'h00018000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 4'd3, 32'h00000000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd4, 32'h00000001, 1'b0};
        vecs[4] = '{16'h0005, 16'hFFFD, 1'b1, 4'd5, 32'h0000000F, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b1, 4'd6, 32'h40000000, 1'b0};
        vecs[6] = '{16'h1234, 16'h0000, 1'b0, 4'd7, 32'h00000000, 1'b0};
        vecs[7] = '{16'h0000, 16'h8000, 1'b1, 4'd8, 32'h00000000, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h8001, 1'b0, 4'd9, 32'h3FFFFFFF, 1'b0};

        // Reset with a pair offered: nothing may be captured.
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h5678;
        signed_mode = 1'b0; tag = 4'hF; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_x_zero",    64'(x == '0), 64'd1);
        check("rst_neg",       64'(neg), 64'd0);
        check("rst_tag_out",   64'(tag_out), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd1);
        repeat (2) begin
            tick();
            check("rst_no_capture", 64'(out_valid), 64'd0);
        end

        foreach (vecs[i]) send_one(vecs[i]);

        // Backpressure: four back-to-back pairs with out_ready low for five cycles.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (acc < 4); tag = 4'(acc + 1);
            a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
            #1;
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b1; tag = 4'(acc + 1);
        #1;
        check("bp_accepts",   64'(acc), 64'd2);
        check("bp_in_ready",  64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_tag",  64'(tag_out), 64'd1);
        out_ready = 1'b1;
        #1;
        check("full_shift_in_ready", 64'(in_ready), 64'd1);
        cyc = 0;
        while (acc < 4 && cyc < 20) begin
            in_valid = 1'b1; tag = 4'(acc + 1);
            a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
            #1;
            if (in_ready) acc++;
            tick();
            cyc++;
            check("full_shift_stays_full", 64'(out_valid), 64'd1);
        end
        check("bp_all_accepted", 64'(acc), 64'd4);
        drain("bp_drain");

        // Random stream with random in_valid / out_ready.
        acc = 0; cyc = 0;
        while (acc < 100 && cyc < 5000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom);
            signed_mode = 1'($urandom); tag = 4'($urandom);
            case ($urandom_range(0, 9))
                0: a = 16'h8000;
                1: b = 16'h0000;
                2: a = 16'hFFFF;
                3: b = 16'h8000;
                default: ;
            endcase
            #1;
            if (in_valid && in_ready) acc++;
            tick();
            cyc++;
        end
        check("stream_accepted", 64'(acc), 64'd100);
        drain("stream_drain");
        check("count_in_out", 64'(out_cnt), 64'(in_cnt));

        // Reset with both stages full: in-flight work is discarded.
        out_ready = 1'b0;
        repeat (2) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            signed_mode = 1'($urandom); tag = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("full_before_rst", 64'(out_valid && !in_ready), 64'd1);
        rst = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_x_zero",    64'(x == '0), 64'd1);
        check("midrst_in_ready",  64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
